counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Run controller for the free-running up-counter datapath: it owns an N-bit count register and decides when, how fast and how far it counts. Software-side logic loads a limit, a prescale divider and a mode through a valid/ready configuration port, then starts, pauses, resumes or aborts the count. The block emits a per-advance tick and a terminal-count done pulse for downstream timing logic, replacing the bare always-counting counter wherever a bounded or periodic count is needed.

## Interface
- N, 8: count width; cnt and cfg_limit width
- P, 4: prescaler width; cfg_prescale width
- clock  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clock
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted this cycle if cfg_valid
- cfg_limit  in  N  terminal count value
- cfg_prescale  in  P  divider: count advances every cfg_prescale+1 cycles
- cfg_periodic  in  1  1 = restart after terminal count, 0 = one-shot
- start  in  1  begin run (IDLE) or resume (HOLD)
- stop  in  1  pause (RUN) or abort (HOLD)
- cnt  out  N  current count, registered
- busy  out  1  state != IDLE
- tick  out  1  one-cycle pulse; high in the cycle cnt shows a newly advanced value
- done  out  1  one-cycle pulse; high in the cycle cnt shows 0 after wrapping from limit

## Operation
- States: IDLE, RUN, HOLD. Internal registers: limit (N), prescale (P), periodic (1), prescale counter pc (P).
- Reset values: state IDLE, cnt 0, pc 0, tick 0, done 0, busy 0, limit all-ones, prescale 0, periodic 0. cfg_ready is 1 after reset.
- cfg_ready = (state == IDLE), combinational. A config transfer on cfg_valid && cfg_ready loads all three config registers. Config is ignored in RUN and HOLD, and while reset is high.
- IDLE: start moves the block to RUN and clears cnt and pc. If a config transfer and start occur in the same cycle, both are accepted and the new config governs the run.
- RUN, each cycle:
  - If pc != prescale: pc += 1.
  - Else: pc ← 0 and the count advances (tick=1 next cycle).
  - Advance when cnt != limit: cnt ← cnt+1.
  - Advance when cnt == limit: cnt ← 0 and done=1. If periodic, stay in RUN; otherwise go to IDLE.
- RUN with stop: go to HOLD; cnt and pc are frozen and no advance occurs that cycle.
- HOLD with start: return to RUN and continue from the frozen cnt and pc. HOLD with stop: go to IDLE and clear cnt and pc.
- Priority: reset > stop > start > advance. start in RUN is ignored.
- Arithmetic is unsigned, with no carry out. limit=0 gives done on every advance. prescale=0 gives an advance every cycle.
- In IDLE, cnt holds its last value (0 after a completed one-shot or an abort).

## Timing
- start sampled at edge E0: busy=1 and cnt=0 after E0.
- With limit L and prescale p, the first tick follows edge E0+(p+1). Ticks follow every p+1 edges thereafter.
- done follows edge E0+(L+1)(p+1), and busy drops at the same edge for a one-shot. Periodic mode repeats with period (L+1)(p+1).
- tick and done are registered and last exactly one cycle. done always coincides with a tick.
- stop takes effect at the sampling edge: an advance due at that edge is suppressed and taken after resume.
- Reset asserted mid-run returns every output to its reset value at the next edge. No pulse is emitted on that edge.

## Test plan
- Reset, then cfg limit=3, prescale=0, one-shot, start: cnt 1,2,3,0 on consecutive cycles; done once with cnt=0; busy low after 4 edges; cfg_ready high again.
- limit=2, prescale=2, periodic: tick every 3rd cycle; done every 9 cycles across 3 periods; busy stays 1.
- limit=5, prescale=0, stop at cnt=2, wait 4 cycles, start: cnt holds 2 with no tick during HOLD, then resumes 3,4,5,0 with done.
- HOLD plus stop: busy→0 and cnt→0. cfg_valid held during RUN: cfg_ready=0 and limit unchanged, verified by done timing.
- Config and start in the same cycle (limit=1): done after 2 edges, confirming the new limit is used. start and stop together in RUN: HOLD entered.
- reset pulsed mid-run at cnt=4: next cycle cnt=0, busy=0, tick=0, done=0, and a subsequent start runs with limit all-ones.

Source files
------------

// File: rtl/counter_sequencer.sv
// Run controller for an N-bit up-counter: configurable limit, prescale divider and
// one-shot/periodic mode, with start/stop/resume/abort control and tick/done pulses.
module counter_sequencer #(
    parameter int N = 8,
    parameter int P = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [N-1:0] cfg_limit,
    input  logic [P-1:0] cfg_prescale,
    input  logic         cfg_periodic,
    input  logic         start,
    input  logic         stop,
    output logic [N-1:0] cnt,
    output logic         busy,
    output logic         tick,
    output logic         done
);

    // IDLE: stopped, config accepted | RUN: counting | HOLD: paused, cnt/pc frozen
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic [P-1:0]   pc_q, pc_d;
    logic           tick_q, tick_d;
    logic           done_q, done_d;
    logic [N-1:0]   limit_q, limit_d;
    logic [P-1:0]   prescale_q, prescale_d;
    logic           periodic_q, periodic_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        limit_d    = limit_q;
        prescale_d = prescale_q;
        periodic_d = periodic_q;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    limit_d    = cfg_limit;
                    prescale_d = cfg_prescale;
                    periodic_d = cfg_periodic;
                end
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    pc_d    = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = HOLD;
                end else if (pc_q != prescale_q) begin
                    pc_d = pc_q + P'(1);
                end else begin
                    pc_d   = '0;
                    tick_d = 1'b1;
                    if (cnt_q == limit_q) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                        if (!periodic_q) state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + N'(1);
                    end
                end
            end
            HOLD: begin
                // stop outranks start: both together abort the run
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pc_d    = '0;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pc_q       <= '0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            limit_q    <= '1;
            prescale_q <= '0;
            periodic_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            limit_q    <= limit_d;
            prescale_q <= prescale_d;
            periodic_q <= periodic_d;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign cnt       = cnt_q;
    assign tick      = tick_q;
    assign done      = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus random traffic, all checked
// against a model that derives cnt/tick/done from the number of active run cycles.
module tb_counter_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_limit = 8'd0;
    logic [3:0] cfg_prescale = 4'd0;
    logic       cfg_periodic = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] cnt;
    logic       busy, tick, done;

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0 idle, 1 run, 2 hold; k = run cycles elapsed since start.
    int         m_mode = 0;
    int         m_k = 0;
    int         m_lim = 255;
    int         m_pre = 0;
    bit         m_per = 1'b0;
    logic [7:0] m_cnt = 8'd0;
    bit         m_tick = 1'b0;
    bit         m_done = 1'b0;

    counter_sequencer #(.N(8), .P(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_limit    (cfg_limit),
        .cfg_prescale (cfg_prescale),
        .cfg_periodic (cfg_periodic),
        .start        (start),
        .stop         (stop),
        .cnt          (cnt),
        .busy         (busy),
        .tick         (tick),
        .done         (done)
    );

    always #5 clock = ~clock;

    function automatic logic [11:0] exp_vec();
        return {m_cnt, (m_mode != 0), m_tick, m_done, (m_mode == 0)};
    endfunction

    function automatic logic [11:0] got_vec();
        return {cnt, busy, tick, done, cfg_ready};
    endfunction

    task automatic cyc();
        int adv;
        @(posedge clock);
        m_tick = 1'b0;
        m_done = 1'b0;
        if (reset) begin
            m_mode = 0; m_k = 0; m_cnt = 8'd0;
            m_lim = 255; m_pre = 0; m_per = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    if (cfg_valid) begin
                        m_lim = int'(cfg_limit);
                        m_pre = int'(cfg_prescale);
                        m_per = cfg_periodic;
                    end
                    if (start) begin
                        m_mode = 1; m_k = 0; m_cnt = 8'd0;
                    end
                end
                1: begin
                    if (stop) begin
                        m_mode = 2;
                    end else begin
                        m_k++;
                        if (m_k % (m_pre + 1) == 0) begin
                            adv    = m_k / (m_pre + 1);
                            m_tick = 1'b1;
                            m_cnt  = 8'(adv % (m_lim + 1));
                            if (adv % (m_lim + 1) == 0) begin
                                m_done = 1'b1;
                                if (!m_per) m_mode = 0;
                            end
                        end
                    end
                end
                default: begin
                    if (stop) begin
                        m_mode = 0; m_k = 0; m_cnt = 8'd0;
                    end else if (start) begin
                        m_mode = 1;
                    end
                end
            endcase
        end
        #1;
    endtask

    task automatic quiet();
        reset = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic configure(input int lim, input int pre, input bit per);
        cfg_valid = 1'b1;
        cfg_limit = 8'(lim);
        cfg_prescale = 4'(pre);
        cfg_periodic = per;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        quiet();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        n_vec++;
        if (got_vec() !== 12'b0000_0000_0001 || got_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_state got=%h want=%h", got_vec(), 12'h001);
        end
    endtask

    task automatic test_oneshot();
        configure(3, 0, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        n_vec++;
        if (cnt !== 8'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL oneshot_start got cnt=%0d busy=%b want cnt=0 busy=1", cnt, busy);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_vec++;
            if (got_vec() !== exp_vec() || cnt !== 8'((i + 1) % 4) || done !== (i == 3)) begin
                n_err++;
                $display("FAIL oneshot step %0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
        n_vec++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL oneshot_end got busy=%b rdy=%b want busy=0 rdy=1", busy, cfg_ready);
        end
    endtask

    task automatic test_periodic();
        configure(2, 2, 1'b1);
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 1; i <= 27; i++) begin
            cyc();
            n_vec++;
            if (got_vec() !== exp_vec() || {tick, done, busy} !== {(i % 3 == 0), (i % 9 == 0), 1'b1}) begin
                n_err++;
                $display("FAIL periodic step %0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
        stop = 1'b1; cyc(); cyc(); stop = 1'b0;
        n_vec++;
        if (got_vec() !== exp_vec() || busy !== 1'b0) begin
            n_err++;
            $display("FAIL periodic_abort got=%h want=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_hold_resume();
        configure(5, 0, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) start = 1'b1;
            cyc();
            start = 1'b0;
            n_vec++;
            if (got_vec() !== exp_vec() || cnt !== 8'd2 || tick !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL hold step %0d got=%h want cnt=2 tick=0", i, got_vec());
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_vec++;
            if (got_vec() !== exp_vec() || cnt !== 8'((3 + i) % 6) || done !== (i == 3)) begin
                n_err++;
                $display("FAIL resume step %0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_abort();
        configure(5, 1, 1'b1);
        start = 1'b1; cyc(); start = 1'b0;
        repeat (5) cyc();
        stop = 1'b1; cyc();
        n_vec++;
        if (got_vec() !== exp_vec() || busy !== 1'b1 || cnt !== 8'd2) begin
            n_err++;
            $display("FAIL abort_hold got=%h want=%h", got_vec(), exp_vec());
        end
        cyc(); stop = 1'b0;
        n_vec++;
        if (got_vec() !== exp_vec() || busy !== 1'b0 || cnt !== 8'd0) begin
            n_err++;
            $display("FAIL abort_idle got=%h want busy=0 cnt=0", got_vec());
        end
    endtask

    task automatic test_cfg_in_run();
        configure(3, 0, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        cfg_valid = 1'b1; cfg_limit = 8'd7;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_vec++;
            if (got_vec() !== exp_vec() || cfg_ready !== (i == 3) || done !== (i == 3)) begin
                n_err++;
                $display("FAIL cfg_in_run step %0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_cfg_with_start();
        cfg_valid = 1'b1; cfg_limit = 8'd1; cfg_prescale = 4'd0; cfg_periodic = 1'b0;
        start = 1'b1;
        cyc();
        quiet();
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_vec++;
            if (got_vec() !== exp_vec() || done !== (i == 1) || busy !== (i == 0)) begin
                n_err++;
                $display("FAIL cfg_with_start step %0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_start_stop_run();
        configure(200, 0, 1'b1);
        start = 1'b1; cyc(); start = 1'b0;
        repeat (3) cyc();
        start = 1'b1; stop = 1'b1; cyc(); quiet();
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_vec++;
            if (got_vec() !== exp_vec() || cnt !== 8'd3 || busy !== 1'b1 || tick !== 1'b0) begin
                n_err++;
                $display("FAIL start_stop_run step %0d got=%h want cnt=3 held", i, got_vec());
            end
        end
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        configure(10, 0, 1'b1);
        start = 1'b1; cyc(); start = 1'b0;
        repeat (4) cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        n_vec++;
        if (got_vec() !== exp_vec() || got_vec() !== 12'h001) begin
            n_err++;
            $display("FAIL reset_mid_run got=%h want=%h", got_vec(), 12'h001);
        end
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            cyc();
            n_vec++;
            if (got_vec() !== exp_vec() || done !== (i == 256) || busy !== (i != 256)) begin
                n_err++;
                $display("FAIL reset_default_limit step %0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            cfg_valid    = ($urandom_range(0, 3) == 0);
            cfg_limit    = 8'($urandom_range(0, 6));
            cfg_prescale = 4'($urandom_range(0, 3));
            cfg_periodic = 1'($urandom_range(0, 1));
            start        = ($urandom_range(0, 5) == 0);
            stop         = ($urandom_range(0, 11) == 0);
            cyc();
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random step %0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_hold_resume();
        test_abort();
        test_cfg_in_run();
        test_cfg_with_start();
        test_start_stop_run();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
